split_target: RTL

SPLIT_TARGET -- requirements
Module: split_target

---
 rtl/bus_pkg.sv | 26 ++
 rtl/target_mem.sv | 35 +++
 rtl/split_target.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared bus widths, latency-counter width and the split-target state encoding.
// Pure declarations; no logic or timing of its own.
// Imported by split_target and target_mem.
package bus_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int IDX_W     = 8;
  localparam int CNT_W     = 4;
  localparam int MEM_DEPTH = 1 << IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_COLLECT,
    ST_WR_ACK,
    ST_RD_WAIT,
    ST_SPLIT_REQ,
    ST_RD_RESP
  } state_e;

  // A latency of zero is treated as one so the counter always has a terminal value.
  function automatic logic [CNT_W-1:0] eff_latency(input int lat);
    return (lat < 1) ? CNT_W'(1) : CNT_W'(lat);
  endfunction

endpackage

// File: rtl/target_mem.sv
// 256 x 8 target storage: synchronous write, combinational read.
// Write lands on the clock edge; read data follows raddr_i in the same cycle.
// Not cleared by reset; each cell powers up holding INIT_SEED + its index (mod 256).
module target_mem
  import bus_pkg::*;
#(
  parameter logic [DATA_W-1:0] INIT_SEED = 8'h00
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] cells [MEM_DEPTH];

  for (genvar g = 0; g < MEM_DEPTH; g++) begin : g_cell
    // Power-up image is seed + address; contents survive reset deliberately.
    logic [DATA_W-1:0] cell_q = INIT_SEED + DATA_W'(g);

    // Each cell captures write data when addressed.
    always_ff @(posedge clk) begin
      if (we_i && (waddr_i == IDX_W'(g))) begin
        cell_q <= wdata_i;
      end
    end

    assign cells[g] = cell_q;
  end

  assign rdata_o = cells[raddr_i];

endmodule

// File: rtl/split_target.sv
// Bus target with 256-byte store; writes collect address and data in any order,
// reads wait READ_LATENCY cycles and optionally release the bus via a split.
// One transaction at a time: strobes arriving while s_ready is low are dropped.
module split_target
  import bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_BASE     = 16'h0000,
  parameter int                READ_LATENCY  = 4,
  parameter logic              SPLIT_EN      = 1'b1,
  parameter logic [DATA_W-1:0] MEM_INIT_DATA = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_addr_in,
  input  logic              s_addr_in_valid,
  input  logic [DATA_W-1:0] s_data_in,
  input  logic              s_data_in_valid,
  input  logic              s_rw,
  input  logic              s_split_grant,
  output logic              s_ack,
  output logic              s_split_ack,
  output logic [DATA_W-1:0] s_data_out,
  output logic              s_data_out_valid,
  output logic              s_split_req,
  output logic              s_ready
);

  localparam logic [CNT_W-1:0] LAT_EFF = eff_latency(READ_LATENCY);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              addr_vld_q;
  logic [DATA_W-1:0] wdata_q;
  logic              data_vld_q;
  logic              ack_q;
  logic              split_ack_q;
  logic              split_req_q;
  logic              dout_vld_q;
  logic [DATA_W-1:0] dout_q;
  logic              ready_q;

  logic              addr_match;
  logic              addr_take;
  logic              data_take;
  logic              wr_fire;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] mem_rdata;

  assign addr_match = (s_addr_in[ADDR_W-1:IDX_W] == ADDR_BASE[ADDR_W-1:IDX_W]);

  // Decide whether this edge completes a write: address and data both held,
  // counting strobes present this cycle as already held.
  always_comb begin
    addr_take = 1'b0;
    data_take = 1'b0;
    wr_fire   = 1'b0;
    wr_idx    = idx_q;
    wr_data   = wdata_q;
    if (state_q == ST_IDLE || state_q == ST_WR_COLLECT) begin
      addr_take = s_addr_in_valid && addr_match && (state_q == ST_IDLE);
      data_take = s_data_in_valid && s_rw;
      wr_idx    = addr_vld_q ? idx_q : s_addr_in[IDX_W-1:0];
      wr_data   = data_take ? s_data_in : wdata_q;
      wr_fire   = (data_take || data_vld_q) && ((addr_take && s_rw) || addr_vld_q);
    end
  end

  target_mem #(
    .INIT_SEED(MEM_INIT_DATA)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_fire),
    .waddr_i (wr_idx),
    .wdata_i (wr_data),
    .raddr_i (idx_q),
    .rdata_o (mem_rdata)
  );

  // Transaction FSM; every bus output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      addr_vld_q  <= 1'b0;
      wdata_q     <= '0;
      data_vld_q  <= 1'b0;
      ack_q       <= 1'b0;
      split_ack_q <= 1'b0;
      split_req_q <= 1'b0;
      dout_vld_q  <= 1'b0;
      dout_q      <= '0;
      ready_q     <= 1'b1;
    end else begin
      ack_q       <= 1'b0;
      split_ack_q <= 1'b0;
      dout_vld_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_WR_COLLECT: begin
          if (wr_fire) begin
            addr_vld_q <= 1'b0;
            data_vld_q <= 1'b0;
            ack_q      <= 1'b1;
            ready_q    <= 1'b0;
            state_q    <= ST_WR_ACK;
          end else begin
            if (data_take) begin
              wdata_q    <= s_data_in;
              data_vld_q <= 1'b1;
            end
            if (addr_take) begin
              idx_q   <= s_addr_in[IDX_W-1:0];
              ready_q <= 1'b0;
              if (s_rw) begin
                addr_vld_q <= 1'b1;
                state_q    <= ST_WR_COLLECT;
              end else begin
                cnt_q       <= LAT_EFF;
                split_ack_q <= SPLIT_EN;
                state_q     <= ST_RD_WAIT;
              end
            end
          end
        end
        ST_WR_ACK: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_RD_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            cnt_q <= '0;
            if (SPLIT_EN) begin
              split_req_q <= 1'b1;
              state_q     <= ST_SPLIT_REQ;
            end else begin
              dout_q     <= mem_rdata;
              dout_vld_q <= 1'b1;
              ack_q      <= 1'b1;
              state_q    <= ST_RD_RESP;
            end
          end
        end
        ST_SPLIT_REQ: begin
          if (s_split_grant) begin
            split_req_q <= 1'b0;
            dout_q      <= mem_rdata;
            dout_vld_q  <= 1'b1;
            ack_q       <= 1'b1;
            state_q     <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ack            = ack_q;
  assign s_split_ack      = split_ack_q;
  assign s_split_req      = split_req_q;
  assign s_data_out_valid = dout_vld_q;
  assign s_data_out       = dout_q;
  assign s_ready          = ready_q;

endmodule
